// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the IF stage, the next-PC mux and the DC stage.
package instruction_fetch_stage_pkg;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_INSTR_W = 32;

    localparam logic [DEF_ADDR_W-1:0]  DEF_RESET_PC = 16'h0000;
    localparam logic [DEF_INSTR_W-1:0] NOP_INSTR    = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_DRAIN
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the IF stage and memory.
interface instruction_fetch_stage_if
    import instruction_fetch_stage_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
);
    logic               req;
    logic [ADDR_W-1:0]  addr;
    logic               ack;
    logic [INSTR_W-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instruction_fetch_stage_if_hold_buffer.sv
// Single-entry parking register for an instruction that arrived while the pipe was stalled.
module instruction_fetch_stage_if_hold_buffer #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ADDR_W-1:0]  pc_1_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_1_out,
    output logic               full
);
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_1_q, pc_1_d;
    logic               full_q, full_d;

    // Load wins over clear so a capture is never lost to a same-cycle release.
    always_comb begin
        instr_d = instr_q;
        pc_1_d  = pc_1_q;
        full_d  = full_q;
        if (load) begin
            instr_d = instr_in;
            pc_1_d  = pc_1_in;
            full_d  = 1'b1;
        end else if (clear) begin
            full_d  = 1'b0;
        end
    end

    // Buffer storage, emptied by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
            pc_1_q  <= '0;
            full_q  <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_1_q  <= pc_1_d;
            full_q  <= full_d;
        end
    end

    assign instr_out = instr_q;
    assign pc_1_out  = pc_1_q;
    assign full      = full_q;
endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: program counter, instruction-memory handshake and the IF/DC pipeline register.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         next_pc,
    input  logic                      stall,
    input  logic                      flush,
    instruction_fetch_stage_if.master imem,
    output logic [ADDR_W-1:0]         pc_1,
    output logic [INSTR_W-1:0]        ir_dc,
    output logic [ADDR_W-1:0]         pc_1_dc,
    output logic                      valid_dc,
    output logic                      fetch_busy
);
    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  redirect_pc_q, redirect_pc_d;
    logic [INSTR_W-1:0] ir_dc_q, ir_dc_d;
    logic [ADDR_W-1:0]  pc_1_dc_q, pc_1_dc_d;
    logic               valid_dc_q, valid_dc_d;

    logic               buf_load, buf_clear, buf_full;
    logic [INSTR_W-1:0] buf_instr;
    logic [ADDR_W-1:0]  buf_pc_1;
    logic               ack;

    assign ack  = imem.ack;
    assign pc_1 = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    instruction_fetch_stage_if_hold_buffer #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_hold_buffer (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .clear     (buf_clear),
        .instr_in  (imem.rdata),
        .pc_1_in   (pc_1),
        .instr_out (buf_instr),
        .pc_1_out  (buf_pc_1),
        .full      (buf_full)
    );

    // Fetch state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: flush beats stall, and an outstanding request only ends on ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (flush)               state_d = ack ? ST_FETCH : ST_DRAIN;
                else if (ack && stall)   state_d = ST_HOLD;
            end
            ST_HOLD:  if (flush || !stall) state_d = ST_FETCH;
            ST_DRAIN: if (ack)           state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: PC, redirect target, IF/DC register and hold-buffer control.
    always_comb begin
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        ir_dc_d       = ir_dc_q;
        pc_1_dc_d     = pc_1_dc_q;
        valid_dc_d    = valid_dc_q;
        buf_load      = 1'b0;
        buf_clear     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (flush) begin
                    valid_dc_d = 1'b0;
                    if (ack) pc_d          = next_pc;
                    else     redirect_pc_d = next_pc;
                end else if (ack && !stall) begin
                    ir_dc_d    = imem.rdata;
                    pc_1_dc_d  = pc_1;
                    valid_dc_d = 1'b1;
                    pc_d       = next_pc;
                end else if (ack) begin
                    buf_load   = 1'b1;
                end else if (!stall) begin
                    valid_dc_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    buf_clear  = 1'b1;
                    valid_dc_d = 1'b0;
                    pc_d       = next_pc;
                end else if (!stall) begin
                    buf_clear  = 1'b1;
                    ir_dc_d    = buf_instr;
                    pc_1_dc_d  = buf_pc_1;
                    valid_dc_d = buf_full;
                    pc_d       = next_pc;
                end
            end
            ST_DRAIN: begin
                valid_dc_d = 1'b0;
                if (flush) redirect_pc_d = next_pc;
                if (ack)   pc_d = flush ? next_pc : redirect_pc_q;
            end
            default: begin
                if (flush) valid_dc_d = 1'b0;
            end
        endcase
    end

    // PC, redirect target and IF/DC pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            redirect_pc_q <= RESET_PC;
            ir_dc_q       <= INSTR_W'(NOP_INSTR);
            pc_1_dc_q     <= '0;
            valid_dc_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            redirect_pc_q <= redirect_pc_d;
            ir_dc_q       <= ir_dc_d;
            pc_1_dc_q     <= pc_1_dc_d;
            valid_dc_q    <= valid_dc_d;
        end
    end

    assign imem.req   = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign imem.addr  = pc_q;
    assign fetch_busy = imem.req && !ack;
    assign ir_dc      = ir_dc_q;
    assign pc_1_dc    = pc_1_dc_q;
    assign valid_dc   = valid_dc_q;
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for the IF stage: stream, latency, stall, flush/drain, wrap and reset scenarios.
module tb_instruction_fetch_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [15:0] pc1;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] next_pc;
    logic        stall;
    logic        flush;
    logic [15:0] pc_1;
    logic [31:0] ir_dc;
    logic [15:0] pc_1_dc;
    logic        valid_dc;
    logic        fetch_busy;

    int   n_vec;
    int   n_err;
    exp_t sb_q[$];

    instruction_fetch_stage_if #(.ADDR_W(16), .INSTR_W(32)) imem_bus ();

    instruction_fetch_stage #(
        .ADDR_W   (16),
        .INSTR_W  (32),
        .RESET_PC (16'h0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .next_pc    (next_pc),
        .stall      (stall),
        .flush      (flush),
        .imem       (imem_bus),
        .pc_1       (pc_1),
        .ir_dc      (ir_dc),
        .pc_1_dc    (pc_1_dc),
        .valid_dc   (valid_dc),
        .fetch_busy (fetch_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {~a, a} ^ 32'h5A5A_0000;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0; next_pc = 16'h0000;
        imem_bus.ack = 1'b0; imem_bus.rdata = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Sequential fetch with next_pc = PC+1; memory acks after lat cycles of request.
    task automatic run_stream(input int ncyc, input int lat, input string tag);
        logic [15:0] exp_addr;
        int          wait_cnt;
        bit          idle;
        bit          exp_valid;
        bit          ack;
        exp_t        e;
        exp_addr = 16'h0000; wait_cnt = 0; idle = 1'b1; exp_valid = 1'b0;
        sb_q.delete();
        for (int i = 0; i < ncyc; i++) begin
            n_vec++;
            if (imem_bus.req !== !idle) begin
                n_err++;
                $display("[TB] FAIL %s req c%0d: got %b want %b", tag, i, imem_bus.req, !idle);
            end
            if (!idle) begin
                n_vec++;
                if (imem_bus.addr !== exp_addr) begin
                    n_err++;
                    $display("[TB] FAIL %s addr c%0d: got %h want %h", tag, i, imem_bus.addr, exp_addr);
                end
                n_vec++;
                if (pc_1 !== exp_addr + 16'd1) begin
                    n_err++;
                    $display("[TB] FAIL %s pc_1 c%0d: got %h want %h", tag, i, pc_1, exp_addr + 16'd1);
                end
            end
            n_vec++;
            if (valid_dc !== exp_valid) begin
                n_err++;
                $display("[TB] FAIL %s valid_dc c%0d: got %b want %b", tag, i, valid_dc, exp_valid);
            end
            if (valid_dc === 1'b1) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("[TB] FAIL %s ifdc c%0d: got unexpected instr %h want none", tag, i, ir_dc);
                end else begin
                    e = sb_q.pop_front();
                    if (ir_dc !== e.instr || pc_1_dc !== e.pc1) begin
                        n_err++;
                        $display("[TB] FAIL %s ifdc c%0d: got %h/%h want %h/%h",
                                 tag, i, ir_dc, pc_1_dc, e.instr, e.pc1);
                    end
                end
            end
            ack = !idle && (wait_cnt == lat - 1);
            imem_bus.ack   = ack;
            imem_bus.rdata = ack ? mem_word(exp_addr) : 32'($urandom);
            next_pc        = exp_addr + 16'd1;
            #1;
            n_vec++;
            if (fetch_busy !== (!idle && !ack)) begin
                n_err++;
                $display("[TB] FAIL %s fetch_busy c%0d: got %b want %b", tag, i, fetch_busy, !idle && !ack);
            end
            if (ack) begin
                e.instr = mem_word(exp_addr);
                e.pc1   = exp_addr + 16'd1;
                sb_q.push_back(e);
            end
            step();
            if (ack) begin
                exp_addr = exp_addr + 16'd1;
                wait_cnt = 0;
            end else if (!idle) begin
                wait_cnt++;
            end
            exp_valid = ack;
            idle      = 1'b0;
        end
        imem_bus.ack = 1'b0;
    endtask

    // Reset values while rst is high, then IDLE for one cycle, then fetch from RESET_PC.
    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0; next_pc = 16'h0000;
        imem_bus.ack = 1'b0; imem_bus.rdata = '0;
        step();
        n_vec++;
        if (imem_bus.req !== 1'b0 || valid_dc !== 1'b0 || fetch_busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_ctrl: got req=%b valid=%b busy=%b want 0/0/0", imem_bus.req, valid_dc, fetch_busy);
        end
        n_vec++;
        if (imem_bus.addr !== 16'h0000 || ir_dc !== 32'h0 || pc_1_dc !== 16'h0000) begin
            n_err++;
            $display("[TB] FAIL reset_data: got addr=%h ir=%h pc1dc=%h want zeros", imem_bus.addr, ir_dc, pc_1_dc);
        end
        rst = 1'b0;
        n_vec++;
        if (imem_bus.req !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_idle: got req=%b want 0", imem_bus.req);
        end
        step();
        n_vec++;
        if (imem_bus.req !== 1'b1 || imem_bus.addr !== 16'h0000) begin
            n_err++;
            $display("[TB] FAIL reset_first_fetch: got req=%b addr=%h want 1/0000", imem_bus.req, imem_bus.addr);
        end
    endtask

    task automatic test_zero_wait();
        do_reset();
        run_stream(10, 1, "zero_wait");
    endtask

    task automatic test_latency();
        do_reset();
        run_stream(12, 2, "latency2");
        do_reset();
        run_stream(10, 3, "latency3");
    endtask

    // Stall on the ack cycle at pc=5: instruction parks in HOLD, released when stall drops.
    task automatic test_stall();
        exp_t e;
        do_reset();
        run_stream(6, 1, "pre_stall");
        stall = 1'b1; imem_bus.ack = 1'b1; imem_bus.rdata = mem_word(16'd5); next_pc = 16'h0BAD;
        e.instr = mem_word(16'd5); e.pc1 = 16'd6;
        sb_q.delete();
        sb_q.push_back(e);
        step();
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (imem_bus.req !== 1'b0 || fetch_busy !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL stall_hold_req c%0d: got req=%b busy=%b want 0/0", c, imem_bus.req, fetch_busy);
            end
            n_vec++;
            if (ir_dc !== mem_word(16'd4) || pc_1_dc !== 16'd5 || valid_dc !== 1'b1 || imem_bus.addr !== 16'd5) begin
                n_err++;
                $display("[TB] FAIL stall_frozen c%0d: got ir=%h pc1dc=%h v=%b addr=%h want %h/0005/1/0005",
                         c, ir_dc, pc_1_dc, valid_dc, imem_bus.addr, mem_word(16'd4));
            end
            imem_bus.ack = 1'b0; imem_bus.rdata = 32'($urandom);
            stall   = (c < 2);
            next_pc = stall ? 16'h0BAD : 16'd6;
            step();
        end
        e = sb_q.pop_front();
        n_vec++;
        if (ir_dc !== e.instr || pc_1_dc !== e.pc1 || valid_dc !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL stall_release: got ir=%h pc1dc=%h v=%b want %h/%h/1", ir_dc, pc_1_dc, valid_dc, e.instr, e.pc1);
        end
        n_vec++;
        if (imem_bus.addr !== 16'd6 || imem_bus.req !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL stall_next_addr: got addr=%h req=%b want 0006/1", imem_bus.addr, imem_bus.req);
        end
    endtask

    // Flush without ack at pc=7 drains the old request, then redirects; also a double flush in DRAIN.
    task automatic test_flush_drain();
        exp_t e;
        do_reset();
        run_stream(8, 1, "pre_flush");
        flush = 1'b1; imem_bus.ack = 1'b0; next_pc = 16'h0040;
        step();
        #1;
        n_vec++;
        if (imem_bus.addr !== 16'd7 || imem_bus.req !== 1'b1 || valid_dc !== 1'b0 || fetch_busy !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL drain_enter: got addr=%h req=%b v=%b busy=%b want 0007/1/0/1",
                     imem_bus.addr, imem_bus.req, valid_dc, fetch_busy);
        end
        @(negedge clk);
        flush = 1'b0; stall = 1'b1; next_pc = 16'h0BAD;
        step();
        n_vec++;
        if (imem_bus.addr !== 16'd7 || imem_bus.req !== 1'b1 || valid_dc !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL drain_wait: got addr=%h req=%b v=%b want 0007/1/0", imem_bus.addr, imem_bus.req, valid_dc);
        end
        stall = 1'b0; imem_bus.ack = 1'b1; imem_bus.rdata = 32'hDEAD_BEEF;
        step();
        n_vec++;
        if (imem_bus.addr !== 16'h0040 || imem_bus.req !== 1'b1 || valid_dc !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL drain_redirect: got addr=%h req=%b v=%b want 0040/1/0", imem_bus.addr, imem_bus.req, valid_dc);
        end
        imem_bus.ack = 1'b0; flush = 1'b1; next_pc = 16'h0080;
        step();
        next_pc = 16'h0090;
        step();
        n_vec++;
        if (imem_bus.addr !== 16'h0040 || valid_dc !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL drain2_hold_addr: got addr=%h v=%b want 0040/0", imem_bus.addr, valid_dc);
        end
        flush = 1'b0; imem_bus.ack = 1'b1; imem_bus.rdata = 32'hBAD0_BAD0; next_pc = 16'h0BAD;
        step();
        n_vec++;
        if (imem_bus.addr !== 16'h0090 || valid_dc !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL drain2_redirect: got addr=%h v=%b want 0090/0", imem_bus.addr, valid_dc);
        end
        imem_bus.rdata = mem_word(16'h0090); next_pc = 16'h0091;
        e.instr = mem_word(16'h0090); e.pc1 = 16'h0091;
        sb_q.delete();
        sb_q.push_back(e);
        step();
        imem_bus.ack = 1'b0;
        e = sb_q.pop_front();
        n_vec++;
        if (valid_dc !== 1'b1 || ir_dc !== e.instr || pc_1_dc !== e.pc1) begin
            n_err++;
            $display("[TB] FAIL drain2_deliver: got v=%b ir=%h pc1dc=%h want 1/%h/%h", valid_dc, ir_dc, pc_1_dc, e.instr, e.pc1);
        end
    endtask

    // Flush together with stall in HOLD drops the buffer; PC 16'hFFFF wraps to 16'h0000.
    task automatic test_flush_hold_wrap();
        exp_t e;
        do_reset();
        step();
        imem_bus.ack = 1'b1; imem_bus.rdata = mem_word(16'h0000); next_pc = 16'hFFFE;
        step();
        n_vec++;
        if (imem_bus.addr !== 16'hFFFE || valid_dc !== 1'b1 || pc_1_dc !== 16'h0001) begin
            n_err++;
            $display("[TB] FAIL wrap_jump: got addr=%h v=%b pc1dc=%h want FFFE/1/0001", imem_bus.addr, valid_dc, pc_1_dc);
        end
        stall = 1'b1; imem_bus.rdata = mem_word(16'hFFFE); next_pc = 16'h0BAD;
        step();
        n_vec++;
        if (imem_bus.req !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL wrap_hold: got req=%b want 0", imem_bus.req);
        end
        flush = 1'b1; imem_bus.ack = 1'b0; next_pc = 16'hFFFF;
        step();
        n_vec++;
        if (valid_dc !== 1'b0 || imem_bus.addr !== 16'hFFFF || imem_bus.req !== 1'b1 || pc_1 !== 16'h0000) begin
            n_err++;
            $display("[TB] FAIL hold_flush: got v=%b addr=%h req=%b pc_1=%h want 0/FFFF/1/0000",
                     valid_dc, imem_bus.addr, imem_bus.req, pc_1);
        end
        stall = 1'b0; flush = 1'b0; imem_bus.ack = 1'b1; imem_bus.rdata = mem_word(16'hFFFF); next_pc = 16'h0000;
        e.instr = mem_word(16'hFFFF); e.pc1 = 16'h0000;
        sb_q.delete();
        sb_q.push_back(e);
        step();
        imem_bus.ack = 1'b0;
        e = sb_q.pop_front();
        n_vec++;
        if (valid_dc !== 1'b1 || ir_dc !== e.instr || pc_1_dc !== e.pc1 || imem_bus.addr !== 16'h0000) begin
            n_err++;
            $display("[TB] FAIL wrap_deliver: got v=%b ir=%h pc1dc=%h addr=%h want 1/%h/%h/0000",
                     valid_dc, ir_dc, pc_1_dc, imem_bus.addr, e.instr, e.pc1);
        end
    endtask

    // Reset asserted mid-wait clears outputs immediately, then IDLE, then fetch from RESET_PC.
    task automatic test_reset_mid();
        do_reset();
        step();
        imem_bus.ack = 1'b1; imem_bus.rdata = mem_word(16'h0000); next_pc = 16'h0033;
        step();
        imem_bus.ack = 1'b0;
        step();
        #2;
        n_vec++;
        if (fetch_busy !== 1'b1 || imem_bus.addr !== 16'h0033) begin
            n_err++;
            $display("[TB] FAIL mid_wait: got busy=%b addr=%h want 1/0033", fetch_busy, imem_bus.addr);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (imem_bus.req !== 1'b0 || imem_bus.addr !== 16'h0000 || ir_dc !== 32'h0 ||
            pc_1_dc !== 16'h0000 || valid_dc !== 1'b0 || fetch_busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL async_reset: got req=%b addr=%h ir=%h pc1dc=%h v=%b busy=%b want all zero",
                     imem_bus.req, imem_bus.addr, ir_dc, pc_1_dc, valid_dc, fetch_busy);
        end
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (imem_bus.req !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL post_reset_idle: got req=%b want 0", imem_bus.req);
        end
        step();
        n_vec++;
        if (imem_bus.req !== 1'b1 || imem_bus.addr !== 16'h0000) begin
            n_err++;
            $display("[TB] FAIL post_reset_fetch: got req=%b addr=%h want 1/0000", imem_bus.req, imem_bus.addr);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall();
        test_flush_drain();
        test_flush_hold_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- IF-stage sequential core, directly downstream of the next-PC selection mux.
- Holds the program counter and drives the instruction-memory request/acknowledge interface.
- Feeds the current PC+1 back to the mux, and loads the IF/DC pipeline register (instruction, PC+1, valid).
- Handles hazard stalls, branch/jump flushes, and variable-latency memory.

Parameters:
- ADDR_W, 16, PC and instruction-memory address width.
- INSTR_W, 32, instruction word width.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- next_pc  in  ADDR_W  next-PC value from the next-PC mux, sampled only on PC-update edges.
- stall  in  1  hazard-unit hold request; freezes PC and IF/DC.
- flush  in  1  taken branch/jump; the current IF instruction is killed and PC redirects to next_pc.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  ADDR_W  fetch address; equals the PC register.
- imem_ack  in  1  read-data-valid; may assert in the same cycle as imem_req.
- imem_rdata  in  INSTR_W  instruction word, valid when imem_ack=1.
- pc_1  out  ADDR_W  PC+1, combinational, wraps 16'hFFFF to 16'h0000; goes to the mux PC_1 input.
- ir_dc  out  INSTR_W  IF/DC instruction register.
- pc_1_dc  out  ADDR_W  IF/DC copy of PC+1, used for branch-target generation in DC.
- valid_dc  out  1  IF/DC slot holds a real instruction; 0 marks a bubble.
- fetch_busy  out  1  high in WAIT_ACK or DRAIN while the memory has not yet acknowledged.

Behaviour:
- Reset: asynchronous, active-high. Drives pc=RESET_PC, ir_dc=0, pc_1_dc=0, valid_dc=0, state=IDLE, hold buffer empty. imem_req=0 while rst is high.
- States:
  - IDLE: first cycle after reset release.
  - FETCH: request outstanding.
  - HOLD: instruction captured but stalled.
  - DRAIN: discarding an in-flight request after a flush.
- imem_req=1 in FETCH and DRAIN, else 0. imem_addr stays stable while imem_req=1. A request is never withdrawn before imem_ack.
- IDLE -> FETCH unconditionally.
- FETCH, imem_ack=1, stall=0, flush=0:
  - ir_dc<=imem_rdata, pc_1_dc<=pc_1, valid_dc<=1, pc<=next_pc.
  - Stay in FETCH.
  - With zero-wait memory this gives 1 instruction/cycle; IF/DC updates 1 edge after the ack.
- FETCH, imem_ack=0, no stall/flush: valid_dc<=0 (bubble); PC holds.
- FETCH, imem_ack=1, stall=1, flush=0:
  - imem_rdata and pc_1 go into the hold buffer.
  - IF/DC holds; PC holds; go to HOLD.
- FETCH, imem_ack=0, stall=1: IF/DC and PC hold; request stays outstanding.
- HOLD: imem_req=0.
  - When stall=0: IF/DC<=buffer with valid_dc<=1, pc<=next_pc, go to FETCH.
  - While stall=1: everything holds.
- Flush has priority over stall. Any state with flush=1: valid_dc<=0.
  - FETCH with ack: data discarded, pc<=next_pc, stay FETCH.
  - FETCH without ack: next_pc is latched into redirect_pc, go to DRAIN.
  - HOLD: buffer discarded, pc<=next_pc, go to FETCH.
- DRAIN: keep the old address and req until imem_ack; discard that data; then pc<=redirect_pc and go to FETCH.
  - A second flush in DRAIN overwrites redirect_pc with the newer next_pc.
  - Stall in DRAIN has no effect on draining; valid_dc stays 0.
- Stall with no flush never changes valid_dc except through the rules above. IF/DC is frozen during stall.
- Reset mid-request: the in-flight access is abandoned; the memory model must tolerate req dropping on reset.

Decomposition:
- Shared package holds:
  - fetch-state enum (IDLE, FETCH, HOLD, DRAIN);
  - RESET_PC default;
  - NOP_INSTR constant (all zeros) used for ir_dc reset;
  - ADDR_W/INSTR_W defaults shared with the next-PC mux and DC stage.
- One sub-module: if_hold_buffer. Single-entry register for instruction + PC+1 with load/clear/full flag.

Test Plan:
- Zero-wait memory (ack same cycle), no stall/flush, next_pc=pc_1 looped back, RESET_PC=0 -> imem_addr 0,1,2,3 on consecutive cycles; pc_1_dc 1,2,3 with valid_dc=1 from the second edge on.
- 2-cycle-latency memory -> imem_addr 0 held 2 cycles; valid_dc pattern 0,1,0,1; fetch_busy high during wait cycles.
- Stall asserted on the ack cycle for 3 cycles at pc=5 -> state HOLD, imem_req=0, IF/DC frozen; after stall drops, ir_dc=word@5, pc_1_dc=6, next fetch addr 6.
- Flush with next_pc=16'h0040 while the request at pc=7 has no ack -> DRAIN, addr 7 held until ack, data dropped, valid_dc=0, next imem_addr=16'h0040.
- Flush and stall together in HOLD -> buffer dropped, valid_dc=0, pc=next_pc, FETCH resumes; PC at 16'hFFFF with sequential next_pc -> next addr 16'h0000.
- Assert rst mid-WAIT -> all outputs at reset values immediately (async), IDLE for 1 cycle, then fetch resumes from RESET_PC.
